// File: rtl/logic_arb_pkg.sv
// Shared types and opcode constants for the two-requester logic-unit arbiter.
package logic_arb_pkg;

  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester did not win last time.
import logic_arb_pkg::*;

module rr_arbiter2 (
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default-assign every always_comb output first so no path infers a latch.
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one AND/OR/XOR unit between two requesters with a one-entry response slot.
// Optional saturating performance counters are built when LOGIC_ARB_PERF_EN is defined.
import logic_arb_pkg::*;

module logic_unit_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
`ifdef LOGIC_ARB_PERF_EN
  ,
  output logic [15:0]       perf_cnt0,
  output logic [15:0]       perf_cnt1,
  output logic [15:0]       perf_illegal
`endif
);

  arb_state_t        state;
  req_id_t           last_grant;
  logic [1:0]        grant;
  logic              can_accept;
  logic              accept;
  req_id_t           acc_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] result_d;
  logic              illegal_d;

  rr_arbiter2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // The slot can refill in the same cycle it drains, giving one op per cycle.
  assign can_accept = (state == IDLE) || rsp_ready;
  assign req0_ready = grant[0] && can_accept && !reset;
  assign req1_ready = grant[1] && can_accept && !reset;
  assign accept     = req0_ready || req1_ready;
  assign acc_id     = req_id_t'(grant[1]);

  always_comb begin
    sel_a     = acc_id ? req1_a  : req0_a;
    sel_b     = acc_id ? req1_b  : req0_b;
    sel_op    = acc_id ? req1_op : req0_op;
    result_d  = '0;
    illegal_d = 1'b0;
    case (sel_op)
      OP_W'(OP_AND): result_d = sel_a & sel_b;
      OP_W'(OP_OR):  result_d = sel_a | sel_b;
      OP_W'(OP_XOR): result_d = sel_a ^ sel_b;
      default:       illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= RESP;
        end
        RESP: begin
          if (rsp_ready && !accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        last_grant  <= acc_id;
        rsp_valid   <= 1'b1;
        rsp_id      <= acc_id;
        rsp_result  <= result_d;
        rsp_zero    <= (result_d == '0);
        rsp_illegal <= illegal_d;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt0    <= '0;
      perf_cnt1    <= '0;
      perf_illegal <= '0;
    end else if (accept) begin
      if (!acc_id && perf_cnt0 != 16'hFFFF) perf_cnt0 <= perf_cnt0 + 16'd1;
      if (acc_id && perf_cnt1 != 16'hFFFF)  perf_cnt1 <= perf_cnt1 + 16'd1;
      if (illegal_d && perf_illegal != 16'hFFFF) perf_illegal <= perf_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter; perf counters are checked when LOGIC_ARB_PERF_EN is defined.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
  logic [31:0] rsp_result;
`ifdef LOGIC_ARB_PERF_EN
  logic [15:0] perf_cnt0, perf_cnt1, perf_illegal;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
`ifdef LOGIC_ARB_PERF_EN
    ,
    .perf_cnt0   (perf_cnt0),
    .perf_cnt1   (perf_cnt1),
    .perf_illegal(perf_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id,
                           input logic [31:0] res, input logic z, input logic ill);
    check({tag, "_valid"},   {31'd0, rsp_valid},   {31'd0, v});
    check({tag, "_id"},      {31'd0, rsp_id},      {31'd0, id});
    check({tag, "_result"},  rsp_result,           res);
    check({tag, "_zero"},    {31'd0, rsp_zero},    {31'd0, z});
    check({tag, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, ill});
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, "_rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
    check({tag, "_rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    tick();
    tick();
    check_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    check_rdy("in_reset", 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Single AND request from req0.
    req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 4'b1010;
    rsp_ready = 1'b1; #1;
    check_rdy("single0", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_rsp("and", 1'b1, 1'b0, 32'hF000_F000, 1'b0, 1'b0);

    // Back-to-back OR from req1 while the slot drains.
    req1_valid = 1'b1; req1_a = 32'h0000_FFFF; req1_b = 32'h00FF_0000; req1_op = 4'b1011; #1;
    check_rdy("single1", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_rsp("or", 1'b1, 1'b1, 32'h00FF_FFFF, 1'b0, 1'b0);
    tick();
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // Contention: last winner was req1, so order is 0,1,0,1.
    req0_valid = 1'b1; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F; req0_op = 4'b1100;
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'hFFFF_FFFF; req1_op = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rdy("cont", (i % 2) == 0, (i % 2) == 1);
      tick();
      check_rsp("cont", 1'b1, (i % 2) == 1,
                ((i % 2) == 0) ? 32'hF0F0_0F0F : 32'h1234_5678, 1'b0, 1'b0);
    end

    // Backpressure: slot holds req1's result, nobody is ready.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_rdy("bp", 1'b0, 1'b0);
      tick();
      check_rsp("bp_hold", 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1; #1;
    check_rdy("bp_release", 1'b1, 1'b0);
    tick();
    check_rsp("bp_next", 1'b1, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0);
    req0_valid = 1'b0;

    // XOR of equal operands gives zero; then an illegal opcode.
    req1_a = 32'h1234_5678; req1_b = 32'h1234_5678; req1_op = 4'b1100; #1;
    check_rdy("xor_zero", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_rsp("xor_zero", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_op = 4'b0111;
    tick();
    req0_valid = 1'b0;
    check_rsp("illegal", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    check("idle_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset mid-operation drops the pending response and restores priority to req0.
    req0_valid = 1'b1; req0_a = 32'hAAAA_5555; req0_b = 32'h0F0F_F0F0; req0_op = 4'b1011;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    check_rsp("pre_reset", 1'b1, 1'b0, 32'hAFAF_F5F5, 1'b0, 1'b0);
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_a = 32'h0000_00FF; req1_b = 32'h0000_0F0F; req1_op = 4'b1010; #1;
    check_rdy("mid_reset", 1'b0, 1'b0);
    tick();
    check_rsp("post_reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; rsp_ready = 1'b1; #1;
    check_rdy("post_reset_arb", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_rsp("post_reset_r0", 1'b1, 1'b0, 32'hAFAF_F5F5, 1'b0, 1'b0);
    #1;
    check_rdy("post_reset_r1", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_rsp("post_reset_r1", 1'b1, 1'b1, 32'h0000_000F, 1'b0, 1'b0);
    tick();

`ifdef LOGIC_ARB_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perf_rst0", {16'd0, perf_cnt0}, 32'd0);
    check("perf_rst1", {16'd0, perf_cnt1}, 32'd0);
    check("perf_rst_ill", {16'd0, perf_illegal}, 32'd0);
    req1_valid = 1'b1; req1_a = 32'h1357_9BDF; req1_b = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: req1_op = 4'b1010;
        1: req1_op = 4'b1011;
        2: req1_op = 4'b0000;
        3: req1_op = 4'b1100;
        default: req1_op = 4'b1010;
      endcase
      tick();
    end
    req1_valid = 1'b0;
    tick();
    check("perf_cnt0", {16'd0, perf_cnt0}, 32'd0);
    check("perf_cnt1", {16'd0, perf_cnt1}, 32'd5);
    check("perf_illegal", {16'd0, perf_illegal}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
